button_led_ctrl: RTL and testbench



---
 rtl/button_led_ctrl_pkg.sv | 36 +++
 rtl/button_led_ctrl_debounce.sv | 52 +++++
 rtl/button_led_ctrl.sv | 99 +++++++++
 tb/tb_button_led_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/button_led_ctrl_pkg.sv
// Shared mode encodings and helpers for the button/LED controller.
// Mode advance order is OFF -> ON -> SLOW -> FAST -> OFF.
package button_led_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:  return MODE_ON;
      MODE_ON:   return MODE_SLOW;
      MODE_SLOW: return MODE_FAST;
      default:   return MODE_OFF;
    endcase
  endfunction

  function automatic logic mode_led(input mode_t m, input logic slow_ph, input logic fast_ph);
    case (m)
      MODE_OFF:  return 1'b0;
      MODE_ON:   return 1'b1;
      MODE_SLOW: return slow_ph;
      default:   return fast_ph;
    endcase
  endfunction

endpackage

// File: rtl/button_led_ctrl_debounce.sv
// Two-flop synchronizer, stable-count debounce and rising-edge press pulse.
// Level follows raw DEBOUNCE_CYCLES+2 edges after a clean change; press is one cycle.
module button_led_ctrl_debounce
  import button_led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      // any cycle back at the old level restarts the stability count
      if (s2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = db;
  assign press = db & ~db_q;

endmodule

// File: rtl/button_led_ctrl.sv
// BUT2 toggles which LED is edited, BUT1 advances that LED's mode; LEDs are registered.
// Button edge to LED change is DEBOUNCE_CYCLES+4 edges; blink counters are free-running.
module button_led_ctrl
  import button_led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BLINK_SLOW_CYCLES = 64,
  parameter int BLINK_FAST_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT1,
  input  logic BUT2,
  output logic LED1,
  output logic LED2
);

  localparam int SW = cnt_w(BLINK_SLOW_CYCLES);
  localparam int FW = cnt_w(BLINK_FAST_CYCLES);
  localparam logic [SW-1:0] SLOW_LAST = SW'(BLINK_SLOW_CYCLES - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(BLINK_FAST_CYCLES - 1);

  logic          b1_press;
  logic          b2_press;
  logic          b1_level_unused;
  logic          b2_level_unused;
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic          slow_ph;
  logic          fast_ph;
  logic          sel;
  mode_t         mode1;
  mode_t         mode2;

  button_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .raw   (BUT1),
    .level (b1_level_unused),
    .press (b1_press)
  );

  button_led_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .raw   (BUT2),
    .level (b2_level_unused),
    .press (b2_press)
  );

  // shared phases keep both LEDs aligned when they are in the same blink mode
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_ph  <= 1'b0;
    end else begin
      if (slow_cnt == SLOW_LAST) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + 1'b1;
      end
      if (fast_cnt == FAST_LAST) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + 1'b1;
      end
    end
  end

  // a same-cycle BUT1 press edits the LED selected before the BUT2 toggle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel   <= 1'b0;
      mode1 <= MODE_OFF;
      mode2 <= MODE_OFF;
    end else begin
      if (b1_press) begin
        if (sel) mode2 <= next_mode(mode2);
        else     mode1 <= next_mode(mode1);
      end
      if (b2_press) sel <= ~sel;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED1 <= 1'b0;
      LED2 <= 1'b0;
    end else begin
      LED1 <= mode_led(mode1, slow_ph, fast_ph);
      LED2 <= mode_led(mode2, slow_ph, fast_ph);
    end
  end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed and randomized button sequences against an event-level model of
// press timing, per-LED mode and cycle-count-derived blink phase.
module tb_button_led_ctrl;

  localparam int D  = 16;
  localparam int NS = 64;
  localparam int NF = 16;

  logic CLK = 1'b0;
  logic RST_N;
  logic BUT1 = 1'b0;
  logic BUT2 = 1'b0;
  logic LED1;
  logic LED2;

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  button_led_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .BLINK_SLOW_CYCLES(NS),
    .BLINK_FAST_CYCLES(NF)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BUT1 (BUT1),
    .BUT2 (BUT2),
    .LED1 (LED1),
    .LED2 (LED2)
  );

  // Reference model: k counts clock edges since reset release; a clean press
  // whose raw edge precedes edge e takes effect on the mode at edge e+D+2.
  int k;
  int m1, m2;
  bit msel;
  bit exp1, exp2;
  int ev_edge[$];
  int ev_but[$];

  function automatic bit led_of(input int m, input int kk);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((kk / NS) % 2) == 1;
      default: return ((kk / NF) % 2) == 1;
    endcase
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    bit b1, b2;
    if (!RST_N) begin
      k = 0; m1 = 0; m2 = 0; msel = 1'b0; exp1 = 1'b0; exp2 = 1'b0;
      ev_edge.delete();
      ev_but.delete();
    end else begin
      exp1 = led_of(m1, k);
      exp2 = led_of(m2, k);
      k++;
      b1 = 1'b0;
      b2 = 1'b0;
      while (ev_edge.size() > 0 && ev_edge[0] == k) begin
        if (ev_but[0] == 1) b1 = 1'b1;
        else                b2 = 1'b1;
        void'(ev_edge.pop_front());
        void'(ev_but.pop_front());
      end
      if (b1) begin
        if (msel) m2 = (m2 + 1) % 4;
        else      m1 = (m1 + 1) % 4;
      end
      if (b2) msel = !msel;
    end
  end

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, expv);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      chk("led1", LED1, exp1);
      chk("led2", LED2, exp2);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input bit p1, input bit p2, input int width);
    if (p1) begin BUT1 = 1'b1; ev_edge.push_back(k + D + 3); ev_but.push_back(1); end
    if (p2) begin BUT2 = 1'b1; ev_edge.push_back(k + D + 3); ev_but.push_back(2); end
    cyc(width);
    BUT1 = 1'b0;
    BUT2 = 1'b0;
  endtask

  task automatic glitch(input int which, input int width);
    if (which == 1) BUT1 = 1'b1;
    else            BUT2 = 1'b1;
    cyc(width);
    BUT1 = 1'b0;
    BUT2 = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    cyc(n);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    @(posedge CLK);
    #1;

    // reset held while buttons bounce around: LEDs must stay dark
    repeat (20) begin
      BUT1 = 1'($urandom);
      BUT2 = 1'($urandom);
      cyc(1);
    end
    BUT1 = 1'b0;
    BUT2 = 1'b0;
    cyc(2);
    RST_N = 1'b1;
    cyc(500);

    // single clean press: LED1 to ON exactly D+4 edges after the raw edge
    press(1, 0, 30);
    cyc(40);

    // short BUT1 pulse and fast BUT2 chatter are rejected
    glitch(1, D - 1);
    cyc(30);
    fork
      begin
        repeat (64) begin
          #16 BUT2 = ~BUT2;
          #15 BUT2 = ~BUT2;
        end
        BUT2 = 1'b0;
      end
      cyc(200);
    join
    BUT2 = 1'b0;
    cyc(30);

    // LED1 through SLOW, FAST and wrap back to OFF
    press(1, 0, 25); cyc(200);
    press(1, 0, 25); cyc(100);
    press(1, 0, 25); cyc(100);

    // select LED2, then two presses put it in SLOW
    press(0, 1, 25); cyc(40);
    press(1, 0, 25); cyc(40);
    press(1, 0, 25); cyc(300);

    // simultaneous press from reset edits LED1 and moves selection to LED2
    do_reset(3);
    cyc(5);
    press(1, 1, 25); cyc(40);
    press(1, 0, 25); cyc(60);

    // randomized presses and sub-threshold glitches
    repeat (25) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 2)), int'($urandom_range(1, D - 2)));
        cyc(D + 10);
      end else begin
        press(r[0], r[1], int'($urandom_range(D + 2, 40)));
        cyc(int'($urandom_range(D + 6, 60)));
      end
    end

    // asynchronous reset in the middle of a FAST blink
    do_reset(2);
    cyc(3);
    press(1, 0, 25); cyc(40);
    press(1, 0, 25); cyc(40);
    press(1, 0, 25); cyc(37);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_rst_led1", LED1, 1'b0);
    chk("async_rst_led2", LED2, 1'b0);
    @(posedge CLK);
    #1;
    cyc(5);
    RST_N = 1'b1;
    cyc(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
